dmem_access_unit: RTL and testbench

Multi-cycle data-memory access controller between the MEM pipeline stage and the external data-memory bus. It turns a word load/store held in the MEM stage into a single valid/ready bus transaction and asserts `mem_stall` until the access completes. `mem_stall` freezes EX/MEM, MEM/WB and ID/EX. The loaded word is then returned to MEM/WB. It also detects misaligned addresses, bounds the wait with a timeout, and counts stall cycles.

---
 rtl/dmem_access_unit.sv | 113 +++++++++++
 tb/tb_dmem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Data-memory access controller: turns a MEM-stage lw/sw into one valid/ready
// bus transaction and stalls the pipeline until it completes.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_stall,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic [31:0] stall_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   to_cnt;
    logic               req;

    assign req = mem_read | mem_write;

    // Stall is combinational from IDLE so a new access stalls in its first cycle.
    assign mem_stall = rst & (((state == ST_IDLE) & req) |
                              (state == ST_REQ) |
                              (state == ST_WAIT_RSP));

    // Access FSM with registered bus fields, load data, sticky errors and stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            to_cnt        <= '0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            rdata         <= '0;
            err_misalign  <= 1'b0;
            err_timeout   <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (mem_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (addr[1:0] != 2'b00) begin
                            err_misalign <= 1'b1;
                            rdata        <= ERR_RDATA;
                            state        <= ST_DONE;
                        end else begin
                            bus_addr      <= {addr[31:2], 2'b00};
                            bus_wdata     <= wdata;
                            bus_we        <= mem_write;
                            bus_req_valid <= 1'b1;
                            state         <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        to_cnt        <= '0;
                        state         <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        if (!bus_we) begin
                            rdata <= bus_rsp_data;
                        end
                        state <= ST_DONE;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYC)) begin
                        err_timeout <= 1'b1;
                        rdata       <= ERR_RDATA;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                // Request is deliberately not sampled here to avoid re-issuing the same access.
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit (TIMEOUT_CYC = 8).
module tb_dmem_access_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_stall;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        err_misalign;
    logic        err_timeout;
    logic [31:0] stall_cnt;

    int n_tests;
    int n_fail;
    int n_hs;
    int hs_base;
    logic last_we;

    dmem_access_unit #(
        .TIMEOUT_CYC (8),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .mem_stall     (mem_stall),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_data  (bus_rsp_data),
        .err_misalign  (err_misalign),
        .err_timeout   (err_timeout),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus requests and remember the direction of the last one.
    initial begin
        n_hs    = 0;
        last_we = 1'b0;
    end
    always @(posedge clk) begin
        if (bus_req_valid && bus_req_ready) begin
            n_hs    <= n_hs + 1;
            last_we <= bus_we;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        addr          = 32'h100;
        wdata         = 32'h0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_data  = 32'h0;

        // Reset with a pending request
        step(); step();
        #1;
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_valid", 32'(bus_req_valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
        mem_read = 1'b0;
        rst      = 1'b1;
        step();

        // Best-case load
        mem_read = 1'b1; addr = 32'h100; bus_req_ready = 1'b1;
        #1 check("ld_c0_stall", 32'(mem_stall), 32'd1);
        step();
        check("ld_c1_valid", 32'(bus_req_valid), 32'd1);
        check("ld_c1_addr", bus_addr, 32'h100);
        check("ld_c1_we", 32'(bus_we), 32'd0);
        check("ld_c1_stall", 32'(mem_stall), 32'd1);
        step();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1234_5678;
        check("ld_c2_valid", 32'(bus_req_valid), 32'd0);
        check("ld_c2_stall", 32'(mem_stall), 32'd1);
        step();
        bus_rsp_valid = 1'b0;
        check("ld_c3_stall", 32'(mem_stall), 32'd0);
        check("ld_c3_rdata", rdata, 32'h1234_5678);
        check("ld_c3_cnt", stall_cnt, 32'd3);
        mem_read = 1'b0;
        step();

        // Store with 4 cycles of backpressure
        mem_write = 1'b1; addr = 32'h44; wdata = 32'hCAFE_F00D;
        step();
        for (int i = 0; i < 5; i++) begin
            check("st_req_valid", 32'(bus_req_valid), 32'd1);
            check("st_req_addr", bus_addr, 32'h44);
            check("st_req_we", 32'(bus_we), 32'd1);
            check("st_req_wdata", bus_wdata, 32'hCAFE_F00D);
            if (i == 4) bus_req_ready = 1'b1;
            step();
        end
        bus_req_ready = 1'b0;
        check("st_wait_valid", 32'(bus_req_valid), 32'd0);
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h5555_5555;
        step();
        bus_rsp_valid = 1'b0;
        check("st_done_stall", 32'(mem_stall), 32'd0);
        check("st_done_rdata", rdata, 32'h1234_5678);
        check("st_done_cnt", stall_cnt, 32'd10);
        mem_write = 1'b0;
        step();

        // Misaligned load
        mem_read = 1'b1; addr = 32'h102;
        #1 check("mis_c0_stall", 32'(mem_stall), 32'd1);
        step();
        check("mis_valid", 32'(bus_req_valid), 32'd0);
        check("mis_err", 32'(err_misalign), 32'd1);
        check("mis_rdata", rdata, 32'hDEAD_BEEF);
        check("mis_stall", 32'(mem_stall), 32'd0);
        check("mis_cnt", stall_cnt, 32'd11);
        mem_read = 1'b0;
        step();
        check("mis_idle_valid", 32'(bus_req_valid), 32'd0);

        // Timeout with no response
        mem_read = 1'b1; addr = 32'h200; bus_req_ready = 1'b1;
        step();
        step();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("to_wait_stall", 32'(mem_stall), 32'd1);
            check("to_wait_err", 32'(err_timeout), 32'd0);
            step();
        end
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_rdata", rdata, 32'hDEAD_BEEF);
        check("to_stall", 32'(mem_stall), 32'd0);
        check("to_cnt", stall_cnt, 32'd22);
        mem_read = 1'b0;
        step();
        check("to_idle_valid", 32'(bus_req_valid), 32'd0);
        #1 check("to_idle_stall", 32'(mem_stall), 32'd0);

        // Reset during WAIT_RSP, then a stale response
        mem_read = 1'b1; addr = 32'h300; bus_req_ready = 1'b1;
        step();
        step();
        bus_req_ready = 1'b0;
        step();
        check("mr_wait_stall", 32'(mem_stall), 32'd1);
        rst = 1'b0;
        step();
        check("mr_valid", 32'(bus_req_valid), 32'd0);
        check("mr_rdata", rdata, 32'd0);
        check("mr_cnt", stall_cnt, 32'd0);
        check("mr_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
        check("mr_stall", 32'(mem_stall), 32'd0);
        rst = 1'b1; mem_read = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0000_0BAD;
        step();
        bus_rsp_valid = 1'b0;
        check("stale_rdata", rdata, 32'd0);
        check("stale_valid", 32'(bus_req_valid), 32'd0);
        step();
        check("stale_rdata2", rdata, 32'd0);
        check("stale_stall", 32'(mem_stall), 32'd0);

        // Back-to-back lw then lw+sw (treated as store)
        hs_base = n_hs;
        bus_req_ready = 1'b1;
        mem_read = 1'b1; addr = 32'h400;
        step();
        step();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'hA5A5_A5A5;
        step();
        bus_rsp_valid = 1'b0;
        check("b2b_ld_rdata", rdata, 32'hA5A5_A5A5);
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h408; wdata = 32'h1111_2222;
        step();
        #1 check("b2b_idle_stall", 32'(mem_stall), 32'd1);
        step();
        check("b2b_st_we", 32'(bus_we), 32'd1);
        check("b2b_st_addr", bus_addr, 32'h408);
        check("b2b_st_wdata", bus_wdata, 32'h1111_2222);
        step();
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h7777_7777;
        step();
        bus_rsp_valid = 1'b0;
        check("b2b_st_rdata", rdata, 32'hA5A5_A5A5);
        mem_read = 1'b0; mem_write = 1'b0;
        step();
        step();
        check("b2b_hs_count", 32'(n_hs - hs_base), 32'd2);
        check("b2b_last_we", 32'(last_we), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
